// File: rtl/scan_seq_if.sv
// scan_seq_if: control/status and chain-facing signals of the scan sequencer
// Ports (slave = sequencer view):
//   start, len, npat, seed, exp_sig : run request and configuration from test control
//   so                              : scan-out from the last flop of the chain
//   se, si                          : scan enable and scan-in to the chain
//   busy, done, pass, sig           : run status and compressed signature
interface scan_seq_if #(
    parameter int LW = 8,
    parameter int PW = 8
);
    logic          start;
    logic [LW-1:0] len;
    logic [PW-1:0] npat;
    logic [15:0]   seed;
    logic [15:0]   exp_sig;
    logic          so;
    logic          se;
    logic          si;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   sig;
    modport master (output start, len, npat, seed, exp_sig, so, input se, si, busy, done, pass, sig);
    modport slave  (input start, len, npat, seed, exp_sig, so, output se, si, busy, done, pass, sig);
endinterface

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan-test sequencer shifting LFSR patterns through a flop chain and compressing scan-out into a signature
// Ports:
//   CLK  : clock, rising edge, also clocks the chain under test
//   RSTB : asynchronous active-low reset
//   bus  : scan_seq_if slave (run request/config in, SE/SI to chain, SO from chain, status out)
module scan_seq_ctrl #(
    parameter int LW = 8,
    parameter int PW = 8
) (
    input logic       CLK,
    input logic       RSTB,
    scan_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_UNLOAD  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d, bcnt_q, bcnt_d;
    logic [PW-1:0] npat_q, npat_d, pcnt_q, pcnt_d;
    logic [15:0]   exp_q, exp_d, lfsr_q, lfsr_d, sig_q, sig_d, lfsr_adv, sig_upd;
    logic          first_q, first_d, se_q, se_d, si_q, si_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic          last_bit;

    always_comb begin
        lfsr_adv = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        sig_upd  = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ bus.so) ? 16'h1021 : 16'h0000);
        last_bit = (bcnt_q == len_q - LW'(1));
        state_d  = state_q;
        len_d    = len_q;
        npat_d   = npat_q;
        exp_d    = exp_q;
        lfsr_d   = lfsr_q;
        bcnt_d   = bcnt_q;
        pcnt_d   = pcnt_q;
        first_d  = first_q;
        // SO is compressed on every scan-enabled cycle except the first load, whose chain contents are unknown
        sig_d    = (se_q && !first_q) ? sig_upd : sig_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.start) begin
                len_d   = bus.len;
                npat_d  = bus.npat;
                exp_d   = bus.exp_sig;
                lfsr_d  = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
                sig_d   = 16'h0000;
                bcnt_d  = '0;
                pcnt_d  = '0;
                first_d = 1'b1;
                state_d = (bus.len == '0 || bus.npat == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                lfsr_d  = lfsr_adv;
                bcnt_d  = last_bit ? '0 : bcnt_q + LW'(1);
                state_d = last_bit ? S_CAPTURE : S_SHIFT;
            end
            S_CAPTURE: begin
                pcnt_d  = pcnt_q + PW'(1);
                first_d = 1'b0;
                state_d = (pcnt_d == npat_q) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                bcnt_d  = last_bit ? '0 : bcnt_q + LW'(1);
                state_d = last_bit ? S_DONE : S_UNLOAD;
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are registered from the next state so they line up with the cycle they describe
        se_d   = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
        si_d   = (state_d == S_SHIFT) ? lfsr_d[0] : 1'b0;
        busy_d = (state_d == S_SHIFT) || (state_d == S_CAPTURE) || (state_d == S_UNLOAD);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (sig_d == exp_d);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            npat_q  <= '0;
            exp_q   <= '0;
            lfsr_q  <= '0;
            sig_q   <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
            first_q <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            npat_q  <= npat_d;
            exp_q   <= exp_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            first_q <= first_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.se   = se_q;
    assign bus.si   = si_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;
    assign bus.sig  = sig_q;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: scoreboard bench for scan_seq_ctrl with a behavioural D=~Q flop chain
module tb_scan_seq_ctrl;
    typedef struct {logic se; logic si;} cyc_t;
    typedef struct {logic [15:0] sig; logic pass; int cyc;} res_t;

    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    scan_seq_if #(.LW(8), .PW(8)) bus ();
    scan_seq_ctrl #(.LW(8), .PW(8)) dut (.CLK(CLK), .RSTB(RSTB), .bus(bus));

    always #5 CLK = ~CLK;

    cyc_t cyc_q[$];
    res_t res_q[$];
    int tests = 0;
    int fails = 0;
    int so_mode = 0;
    int chain_len = 8;
    logic [7:0] ch = 8'h0;
    logic tog = 1'b0;
    int busy_cnt = 0;
    logic done_prev = 1'b0;

    always @(posedge CLK) ch <= bus.se ? {ch[6:0], bus.si} : ~ch;
    always @(negedge CLK) tog <= ~tog;
    assign bus.so = (so_mode == 2) ? ch[chain_len-1] : (so_mode == 1) ? 1'b1 : (so_mode == 3) ? tog : 1'b0;

    function automatic logic [15:0] crc(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_run(input int len, input int npat, input logic [15:0] seed, input int mode, output logic [15:0] msig);
        logic [15:0] l;
        logic [7:0] c;
        logic so;
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        msig = 16'h0000;
        c = 8'h00;
        if (len == 0 || npat == 0) return;
        for (int p = 0; p < npat; p++) begin
            for (int b = 0; b < len; b++) begin
                cyc_q.push_back(cyc_t'{1'b1, l[0]});
                so = (mode == 2) ? c[len-1] : (mode == 1) ? 1'b1 : 1'b0;
                if (p > 0) msig = crc(msig, so);
                c = {c[6:0], l[0]};
                l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            end
            cyc_q.push_back(cyc_t'{1'b0, 1'b0});
            c = ~c;
        end
        for (int b = 0; b < len; b++) begin
            cyc_q.push_back(cyc_t'{1'b1, 1'b0});
            so = (mode == 2) ? c[len-1] : (mode == 1) ? 1'b1 : 1'b0;
            msig = crc(msig, so);
            c = {c[6:0], 1'b0};
        end
    endtask

    task automatic start_run(input int len, input int npat, input logic [15:0] seed, input logic [15:0] exp, input int mode);
        @(posedge CLK);
        #1;
        so_mode = mode;
        chain_len = (len > 0 && len <= 8) ? len : 8;
        bus.len = 8'(len);
        bus.npat = 8'(npat);
        bus.seed = seed;
        bus.exp_sig = exp;
        bus.start = 1'b1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got done=%b expected 1 within 300 cycles", bus.done);
        end
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (!RSTB) begin
            busy_cnt = 0;
            done_prev = 1'b0;
        end else begin
            tests++;
            if (bus.busy) begin
                busy_cnt++;
                if (cyc_q.size() == 0) begin
                    fails++;
                    $display("FAIL trace: unexpected busy cycle se=%b si=%b", bus.se, bus.si);
                end else begin
                    cyc_t c;
                    c = cyc_q.pop_front();
                    if ({bus.se, bus.si} !== {c.se, c.si}) begin
                        fails++;
                        $display("FAIL trace: got se=%b si=%b expected se=%b si=%b", bus.se, bus.si, c.se, c.si);
                    end
                end
            end else if ({bus.se, bus.si} !== 2'b00) begin
                fails++;
                $display("FAIL idle_scan: got se=%b si=%b expected 0 0", bus.se, bus.si);
            end
            if (bus.done && !done_prev) begin
                if (res_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL result: unexpected done sig=%h", bus.sig);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("sig", 32'(bus.sig), 32'(r.sig));
                    check("pass", 32'(bus.pass), 32'(r.pass));
                    check("cycles", 32'(busy_cnt), 32'(r.cyc));
                end
                busy_cnt = 0;
            end
            done_prev = bus.done;
        end
    end

    initial begin
        logic [15:0] ms;
        bus.start = 1'b1;
        bus.len = 8'd5;
        bus.npat = 8'd5;
        bus.seed = 16'h1234;
        bus.exp_sig = 16'h0000;
        so_mode = 3;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_se", 32'(bus.se), 32'd0);
        check("rst_si", 32'(bus.si), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_sig", 32'(bus.sig), 32'h0000);
        bus.start = 1'b0;
        so_mode = 0;
        RSTB = 1'b1;

        model_run(0, 3, 16'h1234, 0, ms);
        res_q.push_back(res_t'{16'h0000, 1'b1, 0});
        start_run(0, 3, 16'h1234, 16'h0000, 0);
        check("len0_done_t1", 32'(bus.done), 32'd1);
        wait_done();

        model_run(4, 1, 16'h0000, 0, ms);
        res_q.push_back(res_t'{16'h0000, 1'b1, 9});
        start_run(4, 1, 16'h0000, 16'h0000, 0);
        wait_done();

        model_run(1, 1, 16'hBEEF, 1, ms);
        res_q.push_back(res_t'{16'h1021, 1'b1, 3});
        start_run(1, 1, 16'hBEEF, 16'h1021, 1);
        wait_done();

        model_run(1, 1, 16'hBEEF, 1, ms);
        res_q.push_back(res_t'{16'h1021, 1'b0, 3});
        start_run(1, 1, 16'hBEEF, 16'h1020, 1);
        wait_done();

        model_run(8, 3, 16'h0001, 2, ms);
        res_q.push_back(res_t'{ms, 1'b1, 35});
        start_run(8, 3, 16'h0001, ms, 2);
        wait_done();

        model_run(4, 2, 16'h5A5A, 0, ms);
        res_q.push_back(res_t'{16'h0000, 1'b1, 14});
        start_run(4, 2, 16'h5A5A, 16'h0000, 0);
        @(posedge CLK);
        #1;
        bus.start = 1'b1;
        bus.len = 8'd0;
        bus.npat = 8'd7;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        wait_done();

        model_run(4, 3, 16'h1234, 2, ms);
        start_run(4, 3, 16'h1234, 16'h0000, 2);
        repeat (6) @(posedge CLK);
        #2;
        RSTB = 1'b0;
        #1;
        check("abort_se", 32'(bus.se), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sig", 32'(bus.sig), 32'h0000);
        cyc_q.delete();
        res_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1'b1;

        model_run(1, 1, 16'h0000, 1, ms);
        res_q.push_back(res_t'{16'h1021, 1'b1, 3});
        start_run(1, 1, 16'h0000, 16'h1021, 1);
        wait_done();

        check("trace_drained", 32'(cyc_q.size()), 32'd0);
        check("results_drained", 32'(res_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
